// File: rtl/cpu_ppn_ctl_pkg.sv
// rtl/cpu_ppn_ctl_pkg.sv - shared types and constants for the PPN bus source controller
package cpu_ppn_ctl_pkg;

    localparam int PPN_W    = 14;
    localparam int CNT_W    = 4;
    localparam int TURN_MIN = 1;
    localparam int TURN_MAX = 3;
    localparam int TO_MIN   = 1;
    localparam int TO_MAX   = 15;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        BYP,
        LOOKUP,
        DONE,
        FLT
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        LAPA,
        PT
    } owner_e;

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) begin
            return lo;
        end
        if (v > hi) begin
            return hi;
        end
        return v;
    endfunction

endpackage

// File: rtl/cpu_ppn_source_ctl_if.sv
// rtl/cpu_ppn_source_ctl_if.sv - CPU/page-table side signal bundle of the PPN bus source controller
interface cpu_ppn_source_ctl_if;
    import cpu_ppn_ctl_pkg::*;

    logic             REQ_LA;
    logic             PAGING_EN;
    logic             PT_HIT;
    logic             PT_FAULT;
    logic [PPN_W-1:0] PPN_23_10;
    logic             LAPA_n;
    logic             PT_OE_n;
    logic             PPN_VALID;
    logic             ACK;
    logic             FAULT;
    logic [PPN_W-1:0] PPN_LATCH;

    modport master (
        output REQ_LA, PAGING_EN, PT_HIT, PT_FAULT, PPN_23_10,
        input  LAPA_n, PT_OE_n, PPN_VALID, ACK, FAULT, PPN_LATCH
    );

    modport slave (
        input  REQ_LA, PAGING_EN, PT_HIT, PT_FAULT, PPN_23_10,
        output LAPA_n, PT_OE_n, PPN_VALID, ACK, FAULT, PPN_LATCH
    );

endinterface

// File: rtl/cpu_ppn_turn_cnt.sv
// rtl/cpu_ppn_turn_cnt.sv - loadable down-counter with zero flag, saturating at zero
module cpu_ppn_turn_cnt
    import cpu_ppn_ctl_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_ppn_source_ctl.sv
// rtl/cpu_ppn_source_ctl.sv - PPN_23_10 bus owner sequencer (pass-through vs page table)
// Optional PPN capture register enabled by PPN_CAPTURE_EN.
module cpu_ppn_source_ctl
    import cpu_ppn_ctl_pkg::*;
#(
    parameter int TURN_CYCLES = 1,
    parameter int PT_TIMEOUT  = 15
) (
    input  logic                 sysclk,
    input  logic                 sys_rst,
    cpu_ppn_source_ctl_if.slave  bus
);

    // Counter is loaded with N-1 so that the zero flag marks the Nth cycle in the state.
    localparam int               TURN_EFF = clamp(TURN_CYCLES, TURN_MIN, TURN_MAX);
    localparam int               TO_EFF   = clamp(PT_TIMEOUT, TO_MIN, TO_MAX);
    localparam logic [CNT_W-1:0] TURN_LD  = CNT_W'(TURN_EFF - 1);
    localparam logic [CNT_W-1:0] TO_LD    = CNT_W'(TO_EFF - 1);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           target_q, target_d;
    owner_e           req_tgt;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;
    logic             park;
    logic             lapa_n_q, lapa_n_d;
    logic             pt_oe_n_q, pt_oe_n_d;
    logic             valid_q, valid_d;
    logic             ack_q, ack_d;
    logic             fault_q, fault_d;

    cpu_ppn_turn_cnt u_cnt (
        .clk_i      (sysclk),
        .rst_i      (sys_rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        target_d = target_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        req_tgt  = bus.PAGING_EN ? PT : LAPA;

        case (state_q)
            IDLE: begin
                if (bus.REQ_LA) begin
                    target_d = req_tgt;
                    if ((owner_q == NONE) || (owner_q == req_tgt)) begin
                        owner_d  = req_tgt;
                        state_d  = (req_tgt == PT) ? LOOKUP : BYP;
                        cnt_load = 1'b1;
                        cnt_val  = TO_LD;
                    end else begin
                        // Release the bus first; nobody owns it while it turns around.
                        owner_d  = NONE;
                        state_d  = TURN;
                        cnt_load = 1'b1;
                        cnt_val  = TURN_LD;
                    end
                end
            end
            TURN: begin
                if (!bus.REQ_LA) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    owner_d  = target_q;
                    state_d  = (target_q == PT) ? LOOKUP : BYP;
                    cnt_load = 1'b1;
                    cnt_val  = TO_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            BYP: begin
                state_d = bus.REQ_LA ? DONE : IDLE;
            end
            LOOKUP: begin
                if (!bus.REQ_LA) begin
                    state_d = IDLE;
                end else if (bus.PT_FAULT) begin
                    state_d = FLT;
                end else if (bus.PT_HIT) begin
                    state_d = DONE;
                end else if (cnt_zero) begin
                    state_d = FLT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE, FLT: begin
                if (!bus.REQ_LA) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are computed from the next state so the registered copies line up with it.
        park      = (state_d == IDLE) || (state_d == DONE) || (state_d == FLT);
        lapa_n_d  = !((state_d == BYP) || (park && (owner_d == LAPA)));
        pt_oe_n_d = !((state_d == LOOKUP) || (park && (owner_d == PT)));
        valid_d   = (state_d == DONE);
        ack_d     = (state_d == DONE) && (state_q != DONE);
        fault_d   = (state_d == FLT) && (state_q != FLT);
    end

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            owner_q   <= NONE;
            target_q  <= NONE;
            lapa_n_q  <= 1'b1;
            pt_oe_n_q <= 1'b1;
            valid_q   <= 1'b0;
            ack_q     <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            target_q  <= target_d;
            lapa_n_q  <= lapa_n_d;
            pt_oe_n_q <= pt_oe_n_d;
            valid_q   <= valid_d;
            ack_q     <= ack_d;
            fault_q   <= fault_d;
        end
    end

    assign bus.LAPA_n    = lapa_n_q;
    assign bus.PT_OE_n   = pt_oe_n_q;
    assign bus.PPN_VALID = valid_q;
    assign bus.ACK       = ack_q;
    assign bus.FAULT     = fault_q;

`ifdef PPN_CAPTURE_EN
    logic [PPN_W-1:0] latch_q;

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            latch_q <= '0;
        end else if ((state_d == DONE) && (state_q != DONE)) begin
            latch_q <= bus.PPN_23_10;
        end
    end

    assign bus.PPN_LATCH = latch_q;
`else
    logic unused_ppn;

    assign unused_ppn    = ^bus.PPN_23_10;
    assign bus.PPN_LATCH = '0;
`endif

endmodule

// File: tb/tb_cpu_ppn_source_ctl.sv
// tb/tb_cpu_ppn_source_ctl.sv - self-checking bench for cpu_ppn_source_ctl (PPN_CAPTURE_EN aware)
module tb_cpu_ppn_source_ctl;

    localparam int TURN_CYCLES = 1;
    localparam int PT_TIMEOUT  = 15;
`ifdef PPN_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic sysclk = 1'b0;
    logic sys_rst;

    always #5 sysclk = ~sysclk;

    cpu_ppn_source_ctl_if bus ();

    cpu_ppn_source_ctl #(
        .TURN_CYCLES (TURN_CYCLES),
        .PT_TIMEOUT  (PT_TIMEOUT)
    ) dut (
        .sysclk  (sysclk),
        .sys_rst (sys_rst),
        .bus     (bus.slave)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    int          m_owner = 0;    // 0 none, 1 pass-through, 2 page table
    logic [13:0] m_latch = 14'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
        check("excl", 32'(bus.LAPA_n | bus.PT_OE_n), 32'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_lapa"},  32'(bus.LAPA_n),    32'd1);
        check({tag, "_pt"},    32'(bus.PT_OE_n),   32'd1);
        check({tag, "_valid"}, 32'(bus.PPN_VALID), 32'd0);
        check({tag, "_ack"},   32'(bus.ACK),       32'd0);
        check({tag, "_fault"}, 32'(bus.FAULT),     32'd0);
        check({tag, "_latch"}, 32'(bus.PPN_LATCH), 32'd0);
    endtask

    // mode: 0 hit, 1 fault, 2 hit+fault together, 3 no response (timeout); h = lookup cycle of response
    task automatic run_txn(input bit pg, input int mode, input int h, input bit hold, input logic [13:0] ppn);
        int tgt, turn, exp_cyc, cyc, dead;
        bit exp_ack, got, got_ack, got_flt;
        tgt  = pg ? 2 : 1;
        turn = ((m_owner != 0) && (m_owner != tgt)) ? TURN_CYCLES : 0;
        if (!pg) begin
            exp_cyc = turn + 2;
            exp_ack = 1'b1;
        end else if ((mode == 3) || (h > PT_TIMEOUT)) begin
            exp_cyc = turn + 1 + PT_TIMEOUT;
            exp_ack = 1'b0;
        end else begin
            exp_cyc = turn + 1 + h;
            exp_ack = (mode == 0);
        end
        cyc = 0; dead = 0; got = 0; got_ack = 0; got_flt = 0;
        bus.PAGING_EN = pg;
        bus.PPN_23_10 = ppn;
        bus.REQ_LA    = 1'b1;
        while (!got && (cyc < 40)) begin
            tick();
            cyc++;
            if (bus.LAPA_n && bus.PT_OE_n) dead++;
            if (bus.ACK || bus.FAULT) begin
                got     = 1'b1;
                got_ack = bus.ACK;
                got_flt = bus.FAULT;
            end else if (pg && (mode < 3) && (cyc == turn + h)) begin
                bus.PT_HIT   = (mode == 0) || (mode == 2);
                bus.PT_FAULT = (mode >= 1);
            end
        end
        bus.PT_HIT   = 1'b0;
        bus.PT_FAULT = 1'b0;
        check("txn_done", 32'(got), 32'd1);
        check("latency", 32'(cyc), 32'(exp_cyc));
        check("ack", 32'(got_ack), 32'(exp_ack));
        check("fault", 32'(got_flt), 32'(!exp_ack));
        check("dead_cycles", 32'(dead), 32'(turn));
        check("valid_at_end", 32'(bus.PPN_VALID), 32'(exp_ack));
        m_owner = tgt;
        if (exp_ack) m_latch = CAP ? ppn : 14'h0;
        check("latch", 32'(bus.PPN_LATCH), 32'(m_latch));
        if (hold) begin
            tick();
            check("ack_pulse", 32'(bus.ACK), 32'd0);
            check("fault_pulse", 32'(bus.FAULT), 32'd0);
            check("valid_hold", 32'(bus.PPN_VALID), 32'(exp_ack));
        end
        bus.REQ_LA = 1'b0;
        tick();
        check("valid_drop", 32'(bus.PPN_VALID), 32'd0);
        check("park_lapa", 32'(bus.LAPA_n), 32'(m_owner != 1));
        check("park_pt", 32'(bus.PT_OE_n), 32'(m_owner != 2));
    endtask

    initial begin
        sys_rst       = 1'b1;
        bus.REQ_LA    = 1'b0;
        bus.PAGING_EN = 1'b0;
        bus.PT_HIT    = 1'b0;
        bus.PT_FAULT  = 1'b0;
        bus.PPN_23_10 = 14'h0;
        tick();
        tick();
        check_reset_vals("reset");
        sys_rst = 1'b0;

        // pass-through from reset, then owner change to page table, then hit+fault, then timeout
        run_txn(1'b0, 0, 0, 1'b1, 14'(($urandom)));
        run_txn(1'b1, 0, 3, 1'b0, 14'(($urandom)));
        run_txn(1'b1, 2, 2, 1'b1, 14'(($urandom)));
        run_txn(1'b1, 3, 0, 1'b0, 14'(($urandom)));

        // capture value survives a fault and is replaced on the next completion
        run_txn(1'b1, 0, 2, 1'b1, 14'h2A5C);
        run_txn(1'b1, 1, 1, 1'b0, 14'h1111);
        check("latch_kept", 32'(bus.PPN_LATCH), 32'(CAP ? 14'h2A5C : 14'h0));
        run_txn(1'b0, 0, 0, 1'b0, 14'h0F0F);

        // abort mid-lookup: no pulses, page table keeps the bus
        run_txn(1'b1, 0, 1, 1'b0, 14'h0001);
        bus.PAGING_EN = 1'b1;
        bus.REQ_LA    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("abort_lk_ack", 32'(bus.ACK | bus.FAULT), 32'd0);
        end
        check("abort_lk_pt", 32'(bus.PT_OE_n), 32'd0);
        bus.REQ_LA = 1'b0;
        tick();
        check("abort_lk_pulse", 32'(bus.ACK | bus.FAULT), 32'd0);
        check("abort_lk_park", 32'(bus.PT_OE_n), 32'd0);
        check("abort_lk_lapa", 32'(bus.LAPA_n), 32'd1);

        // reset in the middle of a turnaround
        bus.PAGING_EN = 1'b0;
        bus.REQ_LA    = 1'b1;
        tick();
        check("turn_both_lapa", 32'(bus.LAPA_n), 32'd1);
        check("turn_both_pt", 32'(bus.PT_OE_n), 32'd1);
        sys_rst    = 1'b1;
        bus.REQ_LA = 1'b0;
        tick();
        check_reset_vals("midturn_rst");
        sys_rst = 1'b0;
        m_owner = 0;
        m_latch = 14'h0;

        // turnaround abort releases the bus entirely
        run_txn(1'b0, 0, 0, 1'b0, 14'h0222);
        bus.PAGING_EN = 1'b1;
        bus.REQ_LA    = 1'b1;
        tick();
        bus.REQ_LA = 1'b0;
        tick();
        check("turn_abort_pulse", 32'(bus.ACK | bus.FAULT), 32'd0);
        check("turn_abort_lapa", 32'(bus.LAPA_n), 32'd1);
        check("turn_abort_pt", 32'(bus.PT_OE_n), 32'd1);
        m_owner = 0;

        // randomized transaction mix
        for (int n = 0; n < 40; n++) begin
            int gap, md;
            md = int'($urandom_range(0, 7));
            if (md > 3) md = 0;
            if ((md == 3) && ($urandom_range(0, 1) == 1)) md = 1;
            run_txn(1'(($urandom)), md, int'($urandom_range(1, 8)), 1'(($urandom)), 14'(($urandom)));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
